demultiplexer_1to16_stream: RTL and testbench
=============================================

Name: demultiplexer_1to16_stream

Overview:
Streaming 1-to-16 demultiplexer: routes each accepted M-bit input element to one of 16 output lanes, each lane backed by a one-entry output register with a valid/ready handshake. It is the scatter-side counterpart of the 16-to-1 multiplexer tree: it fans a serial operand stream out to 16 parallel consumers. Lane select is either explicit (in_sel) or an internal round-robin pointer.

Parameters:
M, 8, element width in bits (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  M  input element
in_valid  input  1  input element valid
in_ready  output  1  input accepted when in_valid && in_ready
sel_mode  input  1  1 = auto round-robin pointer, 0 = explicit in_sel
in_sel  input  4  target lane when sel_mode=0
ptr_clr  input  1  synchronous clear of round-robin pointer to 0
out_data  output  16*M  lane k at out_data[(k+1)*M-1 : k*M]
out_valid  output  16  per-lane valid
out_ready  input  16  per-lane ready
ptr  output  4  current round-robin pointer
frame_done  output  1  one-cycle pulse on auto-mode wrap

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, ptr=0, frame_done=0; buffered elements discarded; in_ready follows its combinational rule from the cleared lane state (i.e. high while rst is held).
- Target lane t = sel_mode ? ptr : in_sel.
- in_ready = !out_valid[t] || out_ready[t] (combinational; path out_ready -> in_ready is intentional, documented).
- Accept: in_valid && in_ready -> lane t register loads in_data, out_valid[t]=1 next cycle. Latency 1 cycle input to lane output.
- Drain: out_valid[k] && out_ready[k] -> lane k empties next cycle unless refilled the same cycle.
- Simultaneous drain + refill on the same lane: new data loaded, out_valid[k] stays 1, no bubble.
- Non-target lanes unaffected by input; they drain independently.
- out_data[k] holds its value while out_valid[k]=1 && !out_ready[k]; data of an empty lane holds last value (not cleared).
- Source rule: in_data, sel_mode, in_sel stable while in_valid && !in_ready.
- Pointer: accepted transfer in auto mode -> ptr = ptr+1 mod 16 (15 -> 0). Explicit-mode transfers do not move ptr.
- ptr_clr: ptr=0 next cycle; has priority over increment in the same cycle; the transfer still completes to the old ptr lane.
- frame_done: 1 for exactly the cycle after an auto-mode accept at ptr=15 (unless ptr_clr same cycle, then 0). Reset value 0.
- No state machine beyond the pointer and 16 lane valid bits; no internal FIFO; max 16 elements in flight.

Decomposition:
- Package demux_pkg: localparam NUM_LANES=16, SEL_W=4; typedef logic [SEL_W-1:0] lane_sel_t.
- Sub-module demux_lane_reg #(M): one-entry register slice (load, data, valid, ready, async rst); instantiated 16x via generate. Top holds pointer, target decode, in_ready mux, frame_done.

Test Plan:
- Reset: assert rst mid-stream with 5 lanes full -> out_valid=16'h0000, ptr=0, frame_done=0 immediately; in_ready=1 after release.
- Explicit mode, out_ready=all 1: send 0xA5 to in_sel=3 -> out_valid[3]=1 and out_data[31:24]=0xA5 one cycle later, other lanes 0.
- Auto mode, out_ready=0: 16 accepts of values 0..15 -> lane k holds k, ptr wraps to 0, frame_done pulses once; 17th in_valid sees in_ready=0 (lane 0 full).
- Backpressure: lane 5 full, out_ready[5]=0, in_sel=5 -> in_ready=0, out_data[47:40] held; raise out_ready[5] -> same-cycle drain+refill, out_valid[5] stays 1, new value next cycle.
- ptr_clr at ptr=15 with accept -> data to lane 15, ptr=0, frame_done=0.
- Random: random in_valid/out_ready/sel_mode over 10k cycles vs scoreboard per lane -> no loss, duplication or reordering per lane.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane-count constants and lane select type for the 1-to-16 stream demux
package demux_pkg;
    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/demux_lane_reg.sv
// rtl/demux_lane_reg.sv - one-entry output register slice with valid/ready handshake
module demux_lane_reg #(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [M-1:0] i_data,
    input  logic         i_ready,
    output logic [M-1:0] o_data,
    output logic         o_valid
);
    logic [M-1:0] r_data;
    logic         r_valid;

    // A load wins over a drain so a same-cycle drain+refill keeps the lane full without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/demultiplexer_1to16_stream.sv
// rtl/demultiplexer_1to16_stream.sv - streaming 1-to-16 demux with explicit or round-robin lane select
module demultiplexer_1to16_stream
    import demux_pkg::*;
#(
    parameter int M = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sel_mode,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   ptr_clr,
    output logic [NUM_LANES*M-1:0] out_data,
    output logic [NUM_LANES-1:0]   out_valid,
    input  logic [NUM_LANES-1:0]   out_ready,
    output logic [SEL_W-1:0]       ptr,
    output logic                   frame_done
);
    lane_sel_t              r_ptr;
    logic                   r_frame_done;
    lane_sel_t              w_target;
    logic                   w_accept;
    logic                   w_auto_accept;
    logic [NUM_LANES-1:0]   w_load;
    logic [NUM_LANES-1:0]   w_lane_valid;

    assign w_target = sel_mode ? r_ptr : lane_sel_t'(in_sel);

    // Combinational out_ready -> in_ready path lets a full lane accept while it drains.
    assign in_ready      = !w_lane_valid[w_target] || out_ready[w_target];
    assign w_accept      = in_valid && in_ready;
    assign w_auto_accept = w_accept && sel_mode;

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            assign w_load[k] = w_accept && (w_target == lane_sel_t'(k));

            demux_lane_reg #(.M(M)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[k]),
                .i_data  (in_data),
                .i_ready (out_ready[k]),
                .o_data  (out_data[k*M +: M]),
                .o_valid (w_lane_valid[k])
            );
        end
    endgenerate

    // Clear beats increment; the element accepted this cycle still lands on the old pointer lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_auto_accept && !ptr_clr &&
                            (r_ptr == lane_sel_t'(NUM_LANES - 1));
            if (ptr_clr) begin
                r_ptr <= '0;
            end else if (w_auto_accept) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign out_valid  = w_lane_valid;
    assign ptr        = r_ptr;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_demultiplexer_1to16_stream.sv
// tb/tb_demultiplexer_1to16_stream.sv - scoreboard bench for the 1-to-16 stream demux
module tb_demultiplexer_1to16_stream;
    localparam int M = 8;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic           sel_mode;
    logic [3:0]     in_sel;
    logic           ptr_clr;
    logic [L*M-1:0] out_data;
    logic [L-1:0]   out_valid;
    logic [L-1:0]   out_ready;
    logic [3:0]     ptr;
    logic           frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [M-1:0] q [L][$];
    logic [L-1:0] m_valid;
    logic [3:0]   m_ptr;
    logic         m_fd;

    demultiplexer_1to16_stream #(.M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel_mode   (sel_mode),
        .in_sel     (in_sel),
        .ptr_clr    (ptr_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ptr        (ptr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts acceptance, pointer, frame pulse and lane occupancy; pushes expected data.
    always @(negedge clk) begin
        logic [3:0]   t;
        logic         er;
        logic         acc;
        logic [L-1:0] nv;
        if (rst) begin
            m_valid = '0;
            m_ptr   = '0;
            m_fd    = 1'b0;
            for (int k = 0; k < L; k++) q[k].delete();
            check(out_valid == '0, "rst_out_valid", out_valid, 0);
            check(ptr == 4'd0, "rst_ptr", ptr, 0);
            check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
            check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        end else begin
            check(out_valid == m_valid, "out_valid", out_valid, m_valid);
            check(ptr == m_ptr, "ptr", ptr, m_ptr);
            check(frame_done == m_fd, "frame_done", frame_done, m_fd);
            t   = sel_mode ? m_ptr : in_sel;
            er  = !m_valid[t] || out_ready[t];
            check(in_ready == er, "in_ready", in_ready, er);
            acc = in_valid && er;
            nv  = m_valid & ~out_ready;
            if (acc) begin
                nv[t] = 1'b1;
                q[t].push_back(in_data);
            end
            m_fd    = acc && sel_mode && (m_ptr == 4'd15) && !ptr_clr;
            m_ptr   = ptr_clr ? 4'd0 : ((acc && sel_mode) ? m_ptr + 4'd1 : m_ptr);
            m_valid = nv;
        end
    end

    // Monitor: every presented lane element must match that lane's oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < L; k++) begin
                if (out_valid[k]) begin
                    if (q[k].size() == 0) begin
                        check(1'b0, "lane_unexpected", out_data[k*M +: M], 0);
                    end else begin
                        check(out_data[k*M +: M] == q[k][0], "lane_data",
                              out_data[k*M +: M], q[k][0]);
                        if (out_ready[k]) void'(q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [M-1:0] d, input logic mode, input logic [3:0] sel);
        in_data  = d;
        sel_mode = mode;
        in_sel   = sel;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        bit stall;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; sel_mode = 1'b0;
        in_sel = '0; ptr_clr = 1'b0; out_ready = '0;
        repeat (3) cyc();
        rst = 1'b0;
        #1 check(in_ready == 1'b1, "post_rst_in_ready", in_ready, 1);

        // Explicit single element to lane 3.
        out_ready = 16'hFFFF;
        send(8'hA5, 1'b0, 4'd3);
        check(out_valid == 16'h0008, "expl_valid", out_valid, 16'h0008);
        check(out_data[31:24] == 8'hA5, "expl_data", out_data[31:24], 8'hA5);
        cyc();

        // Five lanes full, then asynchronous reset mid-stream.
        out_ready = '0;
        for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 1'b1, 4'd0);
        send(8'h13, 1'b0, 4'd3);
        send(8'h14, 1'b0, 4'd4);
        check(out_valid == 16'h001F, "five_full", out_valid, 16'h001F);
        check(ptr == 4'd3, "ptr_before_rst", ptr, 3);
        rst = 1'b1;
        #1;
        check(out_valid == 16'h0000, "async_rst_valid", out_valid, 0);
        check(ptr == 4'd0, "async_rst_ptr", ptr, 0);
        check(frame_done == 1'b0, "async_rst_fd", frame_done, 0);
        cyc();
        rst = 1'b0;
        #1 check(in_ready == 1'b1, "rst_release_ready", in_ready, 1);

        // Auto fill of all 16 lanes with no drain.
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 4'd0);
        check(ptr == 4'd0, "wrap_ptr", ptr, 0);
        check(frame_done == 1'b1, "wrap_fd", frame_done, 1);
        check(out_valid == 16'hFFFF, "all_full", out_valid, 16'hFFFF);
        check(out_data[15*M +: M] == 8'd15, "lane15_val", out_data[15*M +: M], 15);
        in_data = 8'd16; sel_mode = 1'b1; in_valid = 1'b1;
        #1 check(in_ready == 1'b0, "seventeenth_blocked", in_ready, 0);
        cyc();
        check(frame_done == 1'b0, "fd_one_cycle", frame_done, 0);
        in_valid = 1'b0;
        out_ready = 16'hFFFF;
        cyc();
        out_ready = '0;

        // Backpressure on lane 5, then same-cycle drain and refill.
        send(8'h55, 1'b0, 4'd5);
        in_data = 8'h66; in_sel = 4'd5; sel_mode = 1'b0; in_valid = 1'b1;
        #1 check(in_ready == 1'b0, "bp_blocked", in_ready, 0);
        cyc();
        check(out_data[47:40] == 8'h55, "bp_hold", out_data[47:40], 8'h55);
        out_ready[5] = 1'b1;
        #1 check(in_ready == 1'b1, "bp_ready_through", in_ready, 1);
        cyc();
        check(out_valid[5] == 1'b1, "refill_valid", out_valid[5], 1);
        check(out_data[47:40] == 8'h66, "refill_data", out_data[47:40], 8'h66);
        in_valid = 1'b0;
        cyc();
        out_ready = 16'hFFFF;

        // ptr_clr coinciding with an accept at ptr=15.
        for (int i = 0; i < 15; i++) send(8'h20 + 8'(i), 1'b1, 4'd0);
        check(ptr == 4'd15, "ptr_at_15", ptr, 15);
        ptr_clr = 1'b1;
        send(8'hF0, 1'b1, 4'd0);
        ptr_clr = 1'b0;
        check(out_valid[15] == 1'b1, "clr_lane15_valid", out_valid[15], 1);
        check(out_data[127:120] == 8'hF0, "clr_lane15_data", out_data[127:120], 8'hF0);
        check(ptr == 4'd0, "clr_ptr", ptr, 0);
        check(frame_done == 1'b0, "clr_fd", frame_done, 0);
        cyc();

        // Random traffic respecting the source hold rule.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            stall = in_valid && !in_ready;
            @(posedge clk);
            #1;
            ptr_clr = 1'b0;
            if (!stall) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                sel_mode = 1'($urandom_range(0, 1));
                in_sel   = 4'($urandom);
                if (!in_valid) ptr_clr = ($urandom_range(0, 15) == 0);
            end
            out_ready = 16'($urandom) | 16'($urandom);
        end

        in_valid = 1'b0; ptr_clr = 1'b0;
        out_ready = 16'hFFFF;
        repeat (4) cyc();
        check(out_valid == 16'h0000, "final_empty", out_valid, 0);
        for (int k = 0; k < L; k++) begin
            check(q[k].size() == 0, "final_queue_empty", q[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
